// File: rtl/hazard_pkg.sv
// Shared types for the hazard control unit: FSM state encoding,
// scoreboard entry layout and the scoreboard match helper.
package hazard_pkg;

   typedef enum logic [1:0] {
      HC_RUN,
      HC_STALL,
      HC_FLUSH
   } hc_state_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
   } sb_entry_t;

   // A read of x0 or a disabled read port never matches.
   function automatic logic rd_match(
      input sb_entry_t  e,
      input logic [4:0] addr,
      input logic       en
   );
      return en && (addr != 5'd0) && e.valid && (e.rd == addr);
   endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight destination tracker: a PEND_DEPTH-deep shift register
// of {valid, rd}, with combinational rs1/rs2 match against all entries.
// Ports: clk, reset_n, push_valid/push_rd (entry 0 input),
//        rs1/rs2 address + enable queries, hit (any match).
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned PEND_DEPTH = 3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       push_valid,
   input  logic [4:0] push_rd,
   input  logic [4:0] rs1_addr,
   input  logic       rs1_en,
   input  logic [4:0] rs2_addr,
   input  logic       rs2_en,
   output logic       hit
);

   sb_entry_t sb_q [PEND_DEPTH];
   sb_entry_t sb_d [PEND_DEPTH];

   always_comb begin
      sb_d[0].valid = push_valid;
      sb_d[0].rd    = push_rd;
      for (int i = 1; i < int'(PEND_DEPTH); i++) begin
         sb_d[i] = sb_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(PEND_DEPTH); i++) begin
            sb_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(PEND_DEPTH); i++) begin
            sb_q[i] <= sb_d[i];
         end
      end
   end

   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < int'(PEND_DEPTH); i++) begin
         hit = hit
             | rd_match(sb_q[i], rs1_addr, rs1_en)
             | rd_match(sb_q[i], rs2_addr, rs2_en);
      end
   end

endmodule

// File: rtl/hazard_control_unit.sv
// Issue/stall/squash controller for the in-order pipeline.
// Inputs: decode operands, EX jump result. Outputs: stall_if, bubble_id,
// flush_if_id, redirect_valid/pc, saturating stall/flush counters.
module hazard_control_unit
   import hazard_pkg::*;
#(
   parameter int unsigned PEND_DEPTH   = 3,
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1_addr,
   input  logic             id_rs1_rd_en,
   input  logic [4:0]       id_rs2_addr,
   input  logic             id_rs2_rd_en,
   input  logic [4:0]       id_rd_addr,
   input  logic             id_rd_wr_en,
   input  logic             ex_jump_taken,
   input  logic [31:0]      ex_jump_target,
   output logic             stall_if,
   output logic             bubble_id,
   output logic             flush_if_id,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam int unsigned FW =
      (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

   hc_state_t         state_q, state_d;
   logic [FW-1:0]     fcnt_q, fcnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic hit;
   logic hazard;
   logic issue;
   logic push_valid;
   logic stall_int;
   logic bubble_int;
   logic flush_int;

   hazard_scoreboard #(
      .PEND_DEPTH (PEND_DEPTH)
   ) u_sb (
      .clk        (clk),
      .reset_n    (reset_n),
      .push_valid (push_valid),
      .push_rd    (id_rd_addr),
      .rs1_addr   (id_rs1_addr),
      .rs1_en     (id_rs1_rd_en),
      .rs2_addr   (id_rs2_addr),
      .rs2_en     (id_rs2_rd_en),
      .hit        (hit)
   );

   assign hazard = id_valid & hit;

   // Jump overrides everything; stall tracks the live hazard so the
   // consumer issues in the very cycle the hazard clears.
   always_comb begin
      state_d    = state_q;
      fcnt_d     = fcnt_q;
      stall_int  = 1'b0;
      bubble_int = 1'b0;
      flush_int  = 1'b0;
      issue      = 1'b0;
      if (ex_jump_taken) begin
         state_d    = HC_FLUSH;
         fcnt_d     = FLUSH_LOAD;
         flush_int  = 1'b1;
         bubble_int = 1'b1;
      end else begin
         case (state_q)
            HC_RUN, HC_STALL: begin
               if (hazard) begin
                  state_d    = HC_STALL;
                  stall_int  = 1'b1;
                  bubble_int = 1'b1;
               end else begin
                  state_d = HC_RUN;
                  issue   = id_valid;
               end
            end
            HC_FLUSH: begin
               flush_int  = 1'b1;
               bubble_int = 1'b1;
               if (fcnt_q == '0) begin
                  state_d = HC_RUN;
               end else begin
                  fcnt_d = fcnt_q - FW'(1);
               end
            end
            default: state_d = HC_RUN;
         endcase
      end
   end

   // Squashed and bubbled slots never create a pending entry.
   assign push_valid = issue & id_rd_wr_en;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_int && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (flush_int && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= HC_RUN;
         fcnt_q      <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         fcnt_q      <= fcnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // While in reset the front end is held safe: nothing executes,
   // nothing is redirected.
   assign stall_if       = reset_n & stall_int;
   assign bubble_id      = ~reset_n | bubble_int;
   assign flush_if_id    = ~reset_n | flush_int;
   assign redirect_valid = reset_n & ex_jump_taken;
   assign redirect_pc    = reset_n ? ex_jump_target : 32'd0;
   assign stall_count    = stall_cnt_q;
   assign flush_count    = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: vector table plus
// hand sequences for reset-mid-stall and counter saturation.
module tb_hazard_control_unit;

   logic        clk;
   logic        reset_n;
   logic        id_valid;
   logic [4:0]  id_rs1_addr;
   logic        id_rs1_rd_en;
   logic [4:0]  id_rs2_addr;
   logic        id_rs2_rd_en;
   logic [4:0]  id_rd_addr;
   logic        id_rd_wr_en;
   logic        ex_jump_taken;
   logic [31:0] ex_jump_target;
   logic        stall_if;
   logic        bubble_id;
   logic        flush_if_id;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [15:0] stall_count;
   logic [15:0] flush_count;

   logic        s_valid;
   logic [4:0]  s_rs1;
   logic        s_rs1_en;
   logic [4:0]  s_rd;
   logic        s_wr_en;
   logic        s_stall;
   logic        s_bubble;
   logic        s_flush;
   logic        s_rv;
   logic [31:0] s_pc;
   logic [3:0]  s_stall_count;
   logic [3:0]  s_flush_count;

   int checks;
   int failures;

   hazard_control_unit #(
      .PEND_DEPTH   (3),
      .FLUSH_CYCLES (1),
      .CNT_W        (16)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .id_valid       (id_valid),
      .id_rs1_addr    (id_rs1_addr),
      .id_rs1_rd_en   (id_rs1_rd_en),
      .id_rs2_addr    (id_rs2_addr),
      .id_rs2_rd_en   (id_rs2_rd_en),
      .id_rd_addr     (id_rd_addr),
      .id_rd_wr_en    (id_rd_wr_en),
      .ex_jump_taken  (ex_jump_taken),
      .ex_jump_target (ex_jump_target),
      .stall_if       (stall_if),
      .bubble_id      (bubble_id),
      .flush_if_id    (flush_if_id),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall_count    (stall_count),
      .flush_count    (flush_count)
   );

   hazard_control_unit #(
      .PEND_DEPTH   (20),
      .FLUSH_CYCLES (1),
      .CNT_W        (4)
   ) u_sat (
      .clk            (clk),
      .reset_n        (reset_n),
      .id_valid       (s_valid),
      .id_rs1_addr    (s_rs1),
      .id_rs1_rd_en   (s_rs1_en),
      .id_rs2_addr    (5'd0),
      .id_rs2_rd_en   (1'b0),
      .id_rd_addr     (s_rd),
      .id_rd_wr_en    (s_wr_en),
      .ex_jump_taken  (1'b0),
      .ex_jump_target (32'd0),
      .stall_if       (s_stall),
      .bubble_id      (s_bubble),
      .flush_if_id    (s_flush),
      .redirect_valid (s_rv),
      .redirect_pc    (s_pc),
      .stall_count    (s_stall_count),
      .flush_count    (s_flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [4:0]  r1;
      logic        e1;
      logic [4:0]  r2;
      logic        e2;
      logic [4:0]  rd;
      logic        we;
      logic        j;
      logic [31:0] tgt;
      logic [3:0]  xo;
      int          sc;
      int          fc;
   } vec_t;

   vec_t tbl [18];

   function automatic vec_t mk(
      input logic        v,
      input logic [4:0]  r1,
      input logic        e1,
      input logic [4:0]  r2,
      input logic        e2,
      input logic [4:0]  rd,
      input logic        we,
      input logic        j,
      input logic [31:0] tgt,
      input logic [3:0]  xo,
      input int          sc,
      input int          fc
   );
      vec_t t;
      t.v = v; t.r1 = r1; t.e1 = e1;
      t.r2 = r2; t.e2 = e2; t.rd = rd;
      t.we = we; t.j = j; t.tgt = tgt;
      t.xo = xo; t.sc = sc; t.fc = fc;
      return t;
   endfunction

   task automatic chk(
      input string       name,
      input logic [31:0] act,
      input logic [31:0] exp
   );
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      id_valid       = t.v;
      id_rs1_addr    = t.r1;
      id_rs1_rd_en   = t.e1;
      id_rs2_addr    = t.r2;
      id_rs2_rd_en   = t.e2;
      id_rd_addr     = t.rd;
      id_rd_wr_en    = t.we;
      ex_jump_taken  = t.j;
      ex_jump_target = t.tgt;
   endtask

   function automatic logic [31:0] outs();
      return {28'd0, stall_if, bubble_id, flush_if_id, redirect_valid};
   endfunction

   initial begin
      vec_t idle;
      vec_t tv;
      int   n;
      checks   = 0;
      failures = 0;
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
      drive(idle);
      s_valid = 0; s_rs1 = 0; s_rs1_en = 0; s_rd = 0; s_wr_en = 0;

      // {stall, bubble, flush, redirect} expected per row
      tbl[0]  = mk(1, 0, 1, 0, 0, 1, 1, 0, 0,       4'b0000, 0, 0);
      tbl[1]  = mk(1, 1, 1, 0, 0, 2, 1, 0, 0,       4'b1100, 0, 0);
      tbl[2]  = mk(1, 1, 1, 0, 0, 2, 1, 0, 0,       4'b1100, 1, 0);
      tbl[3]  = mk(1, 1, 1, 0, 0, 2, 1, 0, 0,       4'b1100, 2, 0);
      tbl[4]  = mk(1, 1, 1, 0, 0, 2, 1, 0, 0,       4'b0000, 3, 0);
      tbl[5]  = mk(1, 3, 1, 4, 1, 0, 0, 0, 0,       4'b0000, 3, 0);
      tbl[6]  = mk(1, 0, 1, 2, 0, 5, 1, 0, 0,       4'b0000, 3, 0);
      tbl[7]  = mk(1, 0, 0, 2, 1, 6, 1, 0, 0,       4'b1100, 3, 0);
      tbl[8]  = mk(1, 0, 0, 2, 1, 6, 1, 0, 0,       4'b0000, 4, 0);
      tbl[9]  = mk(1, 0, 1, 0, 0, 7, 1, 1, 32'h200, 4'b0111, 4, 0);
      tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,       4'b0110, 4, 1);
      tbl[11] = mk(1, 7, 1, 0, 0, 0, 0, 0, 0,       4'b0000, 4, 2);
      tbl[12] = mk(1, 0, 1, 0, 0, 8, 1, 0, 0,       4'b0000, 4, 2);
      tbl[13] = mk(1, 8, 1, 0, 0, 9, 1, 0, 0,       4'b1100, 4, 2);
      tbl[14] = mk(1, 8, 1, 0, 0, 9, 1, 1, 32'h300, 4'b0111, 5, 2);
      tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,       4'b0110, 5, 3);
      tbl[16] = mk(1, 8, 1, 0, 0, 9, 1, 0, 0,       4'b0000, 5, 4);
      tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,       4'b0000, 5, 4);

      // reset held 3 cycles, target nonzero to prove pc is forced
      reset_n = 1'b0;
      ex_jump_target = 32'hDEAD_BEEF;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_outs", outs(), 32'h6);
      chk("rst_pc", redirect_pc, 32'd0);
      chk("rst_sc", 32'(stall_count), 0);
      chk("rst_fc", 32'(flush_count), 0);
      drive(idle);
      reset_n = 1'b1;
      #1;
      chk("rel_outs", outs(), 32'h0);
      chk("rel_sc", 32'(stall_count), 0);
      chk("rel_fc", 32'(flush_count), 0);

      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         drive(tbl[i]);
         #1;
         chk($sformatf("v%0d_outs", i), outs(), 32'(tbl[i].xo));
         chk($sformatf("v%0d_sc", i), 32'(stall_count), tbl[i].sc);
         chk($sformatf("v%0d_fc", i), 32'(flush_count), tbl[i].fc);
         if (tbl[i].j) begin
            chk($sformatf("v%0d_pc", i), redirect_pc, tbl[i].tgt);
         end
      end

      // asynchronous reset in the middle of a stall
      @(negedge clk);
      drive(mk(1, 0, 1, 0, 0, 10, 1, 0, 0, 4'b0, 0, 0));
      @(negedge clk);
      tv = mk(1, 10, 1, 0, 0, 11, 1, 0, 32'h44, 4'b0, 0, 0);
      drive(tv);
      #1;
      chk("ms_stall", outs(), 32'hC);
      #2;
      reset_n = 1'b0;
      #1;
      chk("ms_rst_outs", outs(), 32'h6);
      chk("ms_rst_pc", redirect_pc, 32'd0);
      chk("ms_rst_sc", 32'(stall_count), 0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("ms_rel_outs", outs(), 32'h0);
      chk("ms_rel_fc", 32'(flush_count), 0);
      @(negedge clk);
      drive(idle);

      // CNT_W=4, PEND_DEPTH=20 instance: 20 stall cycles saturate at 15
      @(negedge clk);
      s_valid = 1; s_rs1 = 0; s_rs1_en = 1; s_rd = 1; s_wr_en = 1;
      #1;
      chk("sat_prod", 32'(s_stall), 0);
      @(negedge clk);
      s_rs1 = 1; s_rd = 2;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (!s_stall) break;
         n++;
         @(negedge clk);
      end
      chk("sat_cycles", n, 20);
      chk("sat_count", 32'(s_stall_count), 15);
      s_valid = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline controller for the in-order RISC-V core. It sits beside the IF/ID and ID/EX registers. Each cycle it decides whether the instruction in decode may issue, must stall on a read-after-write hazard, or must be squashed because a jump resolved in EX. It tracks in-flight destination registers in a small scoreboard and produces the stall, bubble, flush and PC-redirect controls. It also keeps saturating stall and flush counters for performance analysis.

## Interface
Parameters:
- PEND_DEPTH, 3: cycles a destination register stays pending after issue, i.e. until its register-file write is visible to a decode-stage read.
- FLUSH_CYCLES, 1: cycles after a taken jump during which IF/ID contents are marked do_not_execute.
- CNT_W, 16: width of the performance counters.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- id_valid  in  1  IF/ID holds an instruction not marked do_not_execute.
- id_rs1_addr  in  5  decode rs1.
- id_rs1_rd_en  in  1  rs1 is read.
- id_rs2_addr  in  5  decode rs2.
- id_rs2_rd_en  in  1  rs2 is read.
- id_rd_addr  in  5  decode rd.
- id_rd_wr_en  in  1  rd is written (already 0 when rd = x0).
- ex_jump_taken  in  1  jump in EX redirects the PC this cycle.
- ex_jump_target  in  32  redirect address.
- stall_if  out  1  hold the PC and IF/ID.
- bubble_id  out  1  load ALU_NONE with rd_wr_en = 0 into ID/EX.
- flush_if_id  out  1  mark the instruction entering IF/ID do_not_execute.
- redirect_valid  out  1  PC must load redirect_pc.
- redirect_pc  out  32  equals ex_jump_target.
- stall_count  out  CNT_W  saturating count of stall cycles.
- flush_count  out  CNT_W  saturating count of flush cycles.

## Operation
- Scoreboard: PEND_DEPTH entries of {valid, rd[4:0]} forming a shift register.
  - Every cycle, entry[0] receives the issuing instruction's rd, with valid = id_rd_wr_en. When nothing issues, entry[0] receives valid = 0.
  - Entry[i] moves to entry[i+1]; the last entry is dropped.
- Hazard: asserted when id_valid and, for rs1 or rs2, rd_en = 1, addr != 0 and any valid entry has a matching rd. The check is combinational over all entries.
- Issue: id_valid and no hazard and no ex_jump_taken.
- State machine:
  - RUN: normal operation. hazard and no jump → STALL. jump → FLUSH.
  - STALL: stall_if = 1 and bubble_id = 1. The hazard clearing → RUN, and the instruction issues in that same cycle. jump → FLUSH.
  - FLUSH: flush_if_id = 1 and bubble_id = 1. A down-counter loaded with FLUSH_CYCLES−1 on entry; leave to RUN when it reaches 0. A new ex_jump_taken reloads the counter.
- The state is registered. All outputs are combinational from state, scoreboard and current inputs, which gives zero-cycle decisions.
- ex_jump_taken in any state, combinationally and in the same cycle:
  - redirect_valid = 1, flush_if_id = 1, bubble_id = 1, stall_if = 0.
  - The wrong-path decode instruction never enters the scoreboard.
- Priority: jump > hazard > issue.
- Counters:
  - stall_count increments in every cycle with stall_if = 1.
  - flush_count increments in every cycle with flush_if_id = 1.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset (asynchronous, while reset_n = 0 and on release):
  - Scoreboard all invalid, state RUN, counters 0, flush counter 0.
  - While reset_n = 0, outputs are forced to stall_if = 0, bubble_id = 1, flush_if_id = 1, redirect_valid = 0, redirect_pc = 0.
  - Reset mid-stall or mid-flush discards all pending state.
- Back-to-back dependency: producer issues in cycle 0, consumer reaches decode in cycle 1.
  - The consumer stalls for cycles 1..PEND_DEPTH and issues in cycle PEND_DEPTH+1.
- A dependency two instructions apart stalls PEND_DEPTH−1 cycles.
- rd = x0, or rd_en = 0, never stalls.
- Jump in cycle t:
  - redirect_valid is high in cycle t only.
  - flush_if_id is high for cycles t..t+FLUSH_CYCLES.
- A jump arriving during STALL cancels the stall in that cycle.
- No bubble ever inserts a valid scoreboard entry.

## Structure
- Shared package hazard_pkg holds:
  - hc_state_t enum {HC_RUN, HC_STALL, HC_FLUSH};
  - sb_entry_t struct {logic valid; logic [4:0] rd;}.
- Sub-module hazard_scoreboard contains the shift register plus the match logic. Its ports are clk, reset_n, push_valid, push_rd, rs1/rs2 queries, and hit.
- The top level holds the FSM, the flush down-counter, the perf counters and the output muxing.

## Test plan
- Reset: hold reset_n = 0 for 3 cycles, then release → bubble_id = 1 and stall_if = 0 during reset; counters 0 and state RUN after release.
- addi x1,x0,5 followed by addi x2,x1,1 (PEND_DEPTH = 3) → stall_if high for exactly 3 cycles, consumer issues in cycle 4, stall_count = 3.
- add x0 write followed by an instruction reading x0, plus an rs2 match with rs2_rd_en = 0 → no stall.
- jal at 0x100 to 0x200, ex_jump_taken in cycle t → redirect_valid = 1 and redirect_pc = 0x200 in cycle t; flush_if_id high for cycles t and t+1; flush_count = 2; no scoreboard entry for the squashed instruction.
- Jump asserted during the second stall cycle → stall_if drops in that same cycle and the state goes to FLUSH; the pending scoreboard entry still drains on schedule.
- CNT_W = 4 with 20 consecutive stall cycles → stall_count saturates at 15.
